sort_frame_loader: RTL
======================

Name: sort_frame_loader

Overview:
- Upstream feeder for the recursive register-based bitonic sorter.
- Collects a serial stream of magnitude samples into a SLICES-wide parallel frame, tags each sample with its arrival index, and launches the sorter with a one-cycle ready pulse.
- Holds a result_valid/result_ack handshake toward the consumer of the sorter outputs.
- Because the sorter's done is sticky until reset, the loader owns sorter re-arming: it pulses sort_reset between frames.

Parameters:
- SLICES, 4, samples per frame; power of two, >= 2; must match the sorter instance.
- SLICE_WIDTH and INDEX_WIDTH come from the project-wide core_params.svh constants; require INDEX_WIDTH >= $clog2(SLICES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample present on in_data
- in_data  in  SLICE_WIDTH  input sample
- in_ready  out  1  loader accepts sample this cycle
- sort_ready  out  1  one-cycle launch pulse to sorter ready
- sort_data  out  [SLICES][SLICE_WIDTH]  frame to sorter data_in
- sort_index  out  [SLICES][INDEX_WIDTH]  frame tags to sorter index_in
- sort_done  in  1  sorter done (sticky until sorter reset)
- sort_reset  out  1  registered reset to sorter
- result_valid  out  1  sorter outputs are valid for downstream
- result_ack  in  1  downstream has consumed the sorted frame

Behaviour:
- Reset/clock: reset is synchronous, active-high; clock is clk.
- Registered outputs on reset: sort_data='0, sort_index='0, sort_ready=0, result_valid=0, sort_reset=1, state=FILL, slot counter=0. sort_reset drops to 0 on the first clock after reset deasserts.
- Reset mid-operation (any state) discards the partial frame and re-arms the sorter (sort_reset=1).
- FILL state:
  - in_ready=1 combinationally in FILL only.
  - A transfer occurs when in_valid&&in_ready. The sample is written to sort_data[k] and k is written to sort_index[k], where k is the slot counter (0 first).
  - k increments per transfer. On the transfer with k==SLICES-1, k wraps to 0 and the state goes to LAUNCH.
  - in_valid=0 cycles stall the fill without side effects.
- LAUNCH state (1 cycle): sort_ready=1; next state WAIT. Latency: the last sample is accepted at edge N; sort_ready is high in the cycle after edge N and low again after edge N+1.
- WAIT state: in_ready=0. Go to HOLD when sort_done=1. sort_data/sort_index stay stable from LAUNCH until CLEAR.
- HOLD state: result_valid=1 (registered, asserted on HOLD entry). When result_ack=1, clear result_valid and go to CLEAR.
  - result_ack outside HOLD is ignored.
  - result_ack in the same cycle as HOLD entry does not count; the ack must be sampled while result_valid=1.
- CLEAR state (1 cycle): sort_reset=1, so the sorter sees reset at the next edge. Next state FILL with k=0. in_ready stays 0 in CLEAR, so the first new sample is accepted in the following FILL cycle.
- Sorter re-arm timing: FILL lasts >= SLICES >= 2 cycles, so the sorter is always out of reset before the next sort_ready.
- Unexpected sort_done in FILL or LAUNCH: ignored; only WAIT samples it.
- Simultaneous reset and in_valid: reset wins; the sample is dropped.
- No combinational path from in_valid to any output. in_ready depends on state only.

Optional Feature:
- Macro SORT_LOADER_OVERRUN_EN.
- When defined:
  - adds output overrun_count [15:0], reset 0;
  - increments once per cycle with in_valid=1 && in_ready=0 (dropped sample);
  - saturates at 16'hFFFF;
  - is cleared only by reset.
- When undefined: the port and counter are absent; dropped samples are silently lost.

Test Plan:
- SLICES=4; feed 0x0040, 0x0010, 0x0030, 0x0020 back to back -> sort_data={0x0020,0x0030,0x0010,0x0040} (slot 3..0), sort_index={3,2,1,0}; sort_ready high exactly one cycle, one cycle after the 4th accept.
- Same frame with in_valid low for 3 cycles between samples 1 and 2 -> identical sort_data/sort_index; k holds during the gaps; a single sort_ready pulse.
- Stub sort_done high 5 cycles after launch; hold result_ack low 10 cycles -> result_valid stays 1, in_ready 0. Ack for 1 cycle -> result_valid 0 next cycle, sort_reset high exactly one cycle, then in_ready=1.
- Assert reset after 2 of 4 samples -> in_ready=1 and k=0 after reset. The next 4 samples produce indices 0..3 with no residue from the aborted frame.
- Two consecutive frames against the real comparison_merge_r (SLICES=4) -> the second frame's sorted outputs are correct, proving the sort_reset re-arm.
- SORT_LOADER_OVERRUN_EN: keep in_valid=1 continuously through one full frame cycle with ack 3 cycles after result_valid -> overrun_count equals the number of LAUNCH+WAIT+HOLD+CLEAR cycles. Preload near saturation -> holds at 16'hFFFF.

Source files
------------

// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame loader that feeds and re-arms the bitonic sorter.
// Optional macro SORT_LOADER_OVERRUN_EN adds a saturating dropped-sample counter.
module sort_frame_loader #(
    parameter int SLICES      = 4,
    // Defaults track the project-wide core_params.svh slice/index widths.
    parameter int SLICE_WIDTH = 16,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [SLICE_WIDTH-1:0]                in_data,
    output logic                                  in_ready,
    output logic                                  sort_ready,
    output logic [SLICES-1:0][SLICE_WIDTH-1:0]    sort_data,
    output logic [SLICES-1:0][INDEX_WIDTH-1:0]    sort_index,
    input  logic                                  sort_done,
    output logic                                  sort_reset,
    output logic                                  result_valid,
    input  logic                                  result_ack
`ifdef SORT_LOADER_OVERRUN_EN
    ,
    output logic [15:0]                           overrun_count
`endif
);

    localparam int K_W = $clog2(SLICES);
    localparam logic [K_W-1:0] K_LAST = K_W'(SLICES - 1);

    localparam logic [2:0] FILL   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;

    generate
        if (INDEX_WIDTH < K_W) begin : g_bad_index_width
            $error("INDEX_WIDTH too narrow to tag every slot");
        end
    endgenerate

    logic [2:0]                               state_q, state_d;
    logic [K_W-1:0]                           k_q, k_d;
    logic [SLICES-1:0][SLICE_WIDTH-1:0]       sort_data_q, sort_data_d;
    logic [SLICES-1:0][INDEX_WIDTH-1:0]       sort_index_q, sort_index_d;
    logic                                     sort_ready_q, sort_ready_d;
    logic                                     result_valid_q, result_valid_d;
    logic                                     sort_reset_q, sort_reset_d;

    assign in_ready     = (state_q == FILL);
    assign sort_ready   = sort_ready_q;
    assign sort_data    = sort_data_q;
    assign sort_index   = sort_index_q;
    assign result_valid = result_valid_q;
    assign sort_reset   = sort_reset_q;

    // sort_ready and sort_reset are launched one edge early so they line up with LAUNCH and CLEAR.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        sort_data_d    = sort_data_q;
        sort_index_d   = sort_index_q;
        sort_ready_d   = 1'b0;
        result_valid_d = result_valid_q;
        sort_reset_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    sort_data_d[k_q]  = in_data;
                    sort_index_d[k_q] = INDEX_WIDTH'(k_q);
                    if (k_q == K_LAST) begin
                        k_d          = '0;
                        state_d      = LAUNCH;
                        sort_ready_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (sort_done) begin
                    state_d        = HOLD;
                    result_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_d        = CLEAR;
                    result_valid_d = 1'b0;
                    sort_reset_d   = 1'b1;
                end
            end
            CLEAR: begin
                state_d = FILL;
                k_d     = '0;
            end
            default: begin
                state_d = FILL;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            k_q            <= '0;
            sort_data_q    <= '0;
            sort_index_q   <= '0;
            sort_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
            sort_reset_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            sort_data_q    <= sort_data_d;
            sort_index_q   <= sort_index_d;
            sort_ready_q   <= sort_ready_d;
            result_valid_q <= result_valid_d;
            sort_reset_q   <= sort_reset_d;
        end
    end

`ifdef SORT_LOADER_OVERRUN_EN
    logic [15:0] overrun_count_q, overrun_count_d;

    assign overrun_count = overrun_count_q;

    always_comb begin
        overrun_count_d = overrun_count_q;
        if (in_valid && !in_ready && (overrun_count_q != 16'hFFFF)) begin
            overrun_count_d = overrun_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_count_q <= '0;
        end else begin
            overrun_count_q <= overrun_count_d;
        end
    end
`endif

endmodule
